// File: rtl/oled_frame_refresh.sv
// Frame refresh engine: walks a PAGES x COLS monochrome framebuffer and streams it to the
// OLED controller as page/column commands followed by data bytes over the shared SPI word port.
module oled_frame_refresh #(
    parameter int unsigned PAGES      = 8,
    parameter int unsigned COLS       = 128,
    parameter int unsigned COL_OFFSET = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START_REFRESH,
    output logic       BUSY,
    output logic       DONE,
    output logic       fb_rd_en,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_rd_data,
    output logic       spi_start,
    output logic [9:0] spi_data,
    input  logic       spi_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PG_CMD = 3'd1,
        S_CL_CMD = 3'd2,
        S_CH_CMD = 3'd3,
        S_FETCH  = 3'd4,
        S_LOAD   = 3'd5,
        S_WAIT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [7:0] OFF_B     = 8'(COL_OFFSET);
    localparam logic [7:0] LAST_COL  = 8'(COLS - 32'd1);
    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 32'd1);

    state_t     r_state;
    state_t     r_ret;
    logic [2:0] r_page;
    logic [7:0] r_col;
    logic       r_busy;
    logic       r_done;
    logic       r_fb_rd_en;
    logic [9:0] r_fb_addr;
    logic       r_spi_start;
    logic [9:0] r_spi_data;

    function automatic logic [9:0] addr_of(input logic [2:0] page, input logic [7:0] col);
        return 10'((32'(page) * COLS) + 32'(col));
    endfunction

    // Frame sequencer; every output is registered on the transition that needs it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_ret       <= S_IDLE;
            r_page      <= 3'd0;
            r_col       <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fb_rd_en  <= 1'b0;
            r_fb_addr   <= 10'd0;
            r_spi_start <= 1'b0;
            r_spi_data  <= 10'd0;
        end else begin
            r_spi_start <= 1'b0;
            r_fb_rd_en  <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START_REFRESH) begin
                        r_state <= S_PG_CMD;
                        r_busy  <= 1'b1;
                        r_page  <= 3'd0;
                        r_col   <= 8'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PG_CMD: begin
                    r_spi_data  <= {2'b00, 8'hB0 | {5'b00000, r_page}};
                    r_spi_start <= 1'b1;
                    r_ret       <= S_CL_CMD;
                    r_state     <= S_WAIT;
                end
                S_CL_CMD: begin
                    r_spi_data  <= {2'b00, 4'h0, OFF_B[3:0]};
                    r_spi_start <= 1'b1;
                    r_ret       <= S_CH_CMD;
                    r_state     <= S_WAIT;
                end
                S_CH_CMD: begin
                    r_spi_data  <= {2'b00, 4'h1, OFF_B[7:4]};
                    r_spi_start <= 1'b1;
                    r_col       <= 8'd0;
                    r_ret       <= S_FETCH;
                    r_state     <= S_WAIT;
                end
                // The read strobe was issued on entry, so the byte is ready in LOAD.
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_spi_data  <= {2'b01, fb_rd_data};
                    r_spi_start <= 1'b1;
                    r_ret       <= S_LOAD;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        case (r_ret)
                            S_CL_CMD: r_state <= S_CL_CMD;
                            S_CH_CMD: r_state <= S_CH_CMD;
                            S_FETCH: begin
                                r_state    <= S_FETCH;
                                r_fb_rd_en <= 1'b1;
                                r_fb_addr  <= addr_of(r_page, 8'd0);
                            end
                            // Return tag S_LOAD marks completion of a data byte.
                            S_LOAD: begin
                                if (r_col != LAST_COL) begin
                                    r_col      <= r_col + 8'd1;
                                    r_state    <= S_FETCH;
                                    r_fb_rd_en <= 1'b1;
                                    r_fb_addr  <= addr_of(r_page, r_col + 8'd1);
                                end else if (r_page != LAST_PAGE) begin
                                    r_page  <= r_page + 3'd1;
                                    r_state <= S_PG_CMD;
                                end else begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign fb_rd_en  = r_fb_rd_en;
    assign fb_addr   = r_fb_addr;
    assign spi_start = r_spi_start;
    assign spi_data  = r_spi_data;

endmodule

// File: tb/tb_oled_frame_refresh.sv
// Directed bench for oled_frame_refresh: default 8x128 instance plus a small
// 2x4 instance with a column offset of 2, each served by an SPI/framebuffer model.
module tb_oled_frame_refresh;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start2;
    logic       busy, done, fb_rd_en, spi_start, spi_done;
    logic [9:0] fb_addr, spi_data;
    logic [7:0] fb_rd_data;
    logic       busy2, done2, fb_rd_en2, spi_start2, spi_done2;
    logic [9:0] fb_addr2, spi_data2;
    logic [7:0] fb_rd_data2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int dly = 3;
    int done_cnt = 0;
    int viol = 0;
    logic [9:0] q_data[$];
    logic [9:0] q_fb[$];
    logic [9:0] q2[$];
    int q_cyc[$];
    int q_dcyc[$];

    oled_frame_refresh dut (
        .CLK(clk), .RST_N(rst_n), .START_REFRESH(start), .BUSY(busy), .DONE(done),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rd_data(fb_rd_data),
        .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done)
    );

    oled_frame_refresh #(.PAGES(2), .COLS(4), .COL_OFFSET(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START_REFRESH(start2), .BUSY(busy2), .DONE(done2),
        .fb_rd_en(fb_rd_en2), .fb_addr(fb_addr2), .fb_rd_data(fb_rd_data2),
        .spi_start(spi_start2), .spi_data(spi_data2), .spi_done(spi_done2)
    );

    // SPI master and framebuffer RAM model for the main instance; logs every word.
    initial begin : model1
        int cnt;
        bit pend;
        logic [9:0] held;
        cnt = 0; pend = 1'b0; held = 10'd0;
        spi_done = 1'b0; fb_rd_data = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0; cnt = 0; spi_done = 1'b0;
            end else begin
                if (pend && spi_data !== held) viol++;
                spi_done = 1'b0;
                if (done) done_cnt++;
                if (fb_rd_en) begin
                    fb_rd_data = fb_addr[7:0];
                    q_fb.push_back(fb_addr);
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        spi_done = 1'b1; pend = 1'b0; q_dcyc.push_back(cyc);
                    end
                end
                if (spi_start) begin
                    q_data.push_back(spi_data); q_cyc.push_back(cyc);
                    held = spi_data; pend = 1'b1; cnt = dly;
                end
            end
        end
    end

    // Same model, reduced, for the offset instance.
    initial begin : model2
        int cnt2;
        cnt2 = 0; spi_done2 = 1'b0; fb_rd_data2 = 8'd0;
        forever begin
            @(negedge clk);
            spi_done2 = 1'b0;
            if (fb_rd_en2) fb_rd_data2 = fb_addr2[7:0];
            if (cnt2 > 0) begin
                cnt2--;
                if (cnt2 == 0) spi_done2 = 1'b1;
            end
            if (spi_start2) begin
                q2.push_back(spi_data2); cnt2 = 3;
            end
        end
    end

    function automatic logic [9:0] exp_word(input int i, input int cols, input int off);
        int wpp, p, k;
        wpp = cols + 3; p = i / wpp; k = i % wpp;
        if (k == 0) return 10'(32'h0B0 | p);
        else if (k == 1) return 10'(off & 15);
        else if (k == 2) return 10'(32'h010 | ((off >> 4) & 15));
        else return 10'(32'h100 | ((p * cols + k - 3) & 255));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        q_data.delete(); q_cyc.delete(); q_dcyc.delete(); q_fb.delete();
        done_cnt = 0; viol = 0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int k;
        k = 0;
        while (q_data.size() < n && k < 20000) begin
            tick(); k++;
        end
        chk({tag, "_wait_words"}, 32'(q_data.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            tick(); k++;
        end
        chk({tag, "_wait_done"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int t0);
        int n, serr, perr, gap;
        serr = 0; perr = 0;
        n = (q_data.size() < 1048) ? q_data.size() : 1048;
        chk({tag, "_word_count"}, 32'(q_data.size()), 32'd1048);
        for (int i = 0; i < n; i++)
            if (q_data[i] !== exp_word(i, 128, 0)) serr++;
        chk({tag, "_sequence_errs"}, 32'(serr), 32'd0);
        for (int i = 0; i < n - 1; i++) begin
            if (i < q_dcyc.size()) begin
                gap = (q_data[i + 1][9:8] == 2'b01) ? 3 : 2;
                if (q_cyc[i + 1] - q_dcyc[i] != gap) perr++;
            end else begin
                perr++;
            end
        end
        chk({tag, "_spacing_errs"}, 32'(perr), 32'd0);
        chk({tag, "_stable_errs"}, 32'(viol), 32'd0);
        chk({tag, "_first_latency"}, 32'((n > 0) ? q_cyc[0] - t0 : -1), 32'd2);
    endtask

    initial begin : stim
        int t0, sz;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_data", 32'(spi_data), 32'd0);
        chk("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        rst_n = 1'b1;
        clear_logs();
        tick(10);
        chk("idle_no_words", 32'(q_data.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Frame 1: stray starts during page 2 and in the DONE cycle.
        clear_logs(); q2.delete();
        t0 = cyc; start = 1'b1; start2 = 1'b1;
        tick(); start = 1'b0; start2 = 1'b0;
        chk("f1_busy_after_start", 32'(busy), 32'd1);
        wait_words(2 * 131 + 10, "f1_page2");
        start = 1'b1; tick(); start = 1'b0;
        wait_done("f1");
        chk("f1_busy_in_done", 32'(busy), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("f1_busy_after_done", 32'(busy), 32'd0);
        chk("f1_done_low", 32'(done), 32'd0);
        tick(20);
        chk("f1_done_once", 32'(done_cnt), 32'd1);
        chk("f1_still_idle", 32'(busy), 32'd0);
        check_frame("f1", t0);

        chk("off_word_count", 32'(q2.size()), 32'd14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("off_word%0d", i), 32'((i < q2.size()) ? q2[i] : 10'h3FF),
                32'(exp_word(i, 4, 2)));
        chk("off_busy", 32'(busy2), 32'd0);

        // Frame 2: fast SPI, then restart on the cycle after DONE.
        dly = 1;
        clear_logs();
        t0 = cyc; start = 1'b1; tick(); start = 1'b0;
        wait_done("f2");
        tick();
        chk("f2_busy_after_done", 32'(busy), 32'd0);
        check_frame("f2", t0);
        dly = 3;
        clear_logs();
        t0 = cyc; start = 1'b1; tick(); start = 1'b0;

        // Frame 3: abort by reset in page 3 data.
        wait_words(3 * 131 + 10, "f3_page3");
        chk("f3_first_word", 32'((q_data.size() > 0) ? q_data[0] : 10'h3FF), 32'h0B0);
        chk("f3_first_latency", 32'((q_cyc.size() > 0) ? q_cyc[0] - t0 : -1), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_spi_start", 32'(spi_start), 32'd0);
        chk("abort_fb_rd_en", 32'(fb_rd_en), 32'd0);
        sz = q_data.size();
        rst_n = 1'b1;
        tick(10);
        chk("abort_no_words", 32'(q_data.size()), 32'(sz));
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // Frame 4: restart from page 0 after abort.
        clear_logs();
        t0 = cyc; start = 1'b1; tick(); start = 1'b0;
        wait_done("f4");
        tick();
        check_frame("f4", t0);
        chk("f4_fb_first_addr", 32'((q_fb.size() > 0) ? q_fb[0] : 10'h3FF), 32'd0);
        chk("f4_fb_reads", 32'(q_fb.size()), 32'd1024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
